// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, MMIO offsets and address decode for dmem_responder
//   state_t : responder FSM states
//   kind_t  : decoded target of an access
//   decode(): maps a byte address to its target
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic [2:0] {
        K_RAM,
        K_LED,
        K_CYCLE,
        K_ERRCLR,
        K_BAD
    } kind_t;

    localparam int          WCNT_W     = 4;
    localparam logic [31:0] OFF_LED    = 32'd0;
    localparam logic [31:0] OFF_CYCLE  = 32'd4;
    localparam logic [31:0] OFF_ERRCLR = 32'd8;

    // Misalignment is checked first so a misaligned MMIO address is an error,
    // not a register hit. With the register bank absent every non-RAM address is bad.
    function automatic kind_t decode(
        input logic [31:0] a,
        input logic [31:0] ram_bytes,
        input logic [31:0] base,
        input logic        mmio_en
    );
        kind_t k;
        k = K_BAD;
        if (a[1:0] != 2'b00)
            k = K_BAD;
        else if (a < ram_bytes)
            k = K_RAM;
        else if (mmio_en && a == base + OFF_LED)
            k = K_LED;
        else if (mmio_en && a == base + OFF_CYCLE)
            k = K_CYCLE;
        else if (mmio_en && a == base + OFF_ERRCLR)
            k = K_ERRCLR;
        return k;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port word RAM, synchronous write and read
//   clk    in   clock
//   we     in   write enable
//   re     in   read enable; rdata holds between reads
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  registered read data
module dmem_ram #(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: word RAM plus optional MMIO bank (DMEM_MMIO_EN)
//   clk       in   clock
//   reset_n   in   asynchronous active-low reset
//   req       in   request valid, held with addr/memwrite/writedata until ready
//   memwrite  in   1 = store, 0 = load
//   addr      in   byte address
//   writedata in   store data
//   readdata  out  load data, valid in the ready cycle and held
//   ready     out  one-cycle completion pulse
//   led       out  MMIO output register
//   err       out  sticky access-error flag
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ready,
    output logic [7:0]  led,
    output logic        err
);

    localparam int                AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0]       RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [WCNT_W-1:0] WS        = WCNT_W'(WAIT_STATES);
`ifdef DMEM_MMIO_EN
    localparam logic MMIO_EN = 1'b1;
`else
    localparam logic MMIO_EN = 1'b0;
`endif

    state_t            state, next_state;
    logic [WCNT_W-1:0] wcnt;
    logic [31:0]       cap_addr;
    logic              cap_we;
    logic [31:0]       cap_wdata;

    logic [31:0]       eff_addr;
    logic              eff_we;
    kind_t             rd_kind;
    kind_t             cap_kind;
    logic              load_done;
    logic              ram_re;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [31:0]       ram_q;
    logic [31:0]       mmio_val;
    logic [31:0]       rd_reg;
    logic              rd_sel_ram;
    logic [31:0]       cycle;

    // With zero wait states the read happens on the accept edge itself, before
    // the capture registers hold the request, so the live inputs are used then.
    assign eff_addr = (state == ST_IDLE) ? addr : cap_addr;
    assign eff_we   = (state == ST_IDLE) ? memwrite : cap_we;
    assign rd_kind  = decode(eff_addr, RAM_BYTES, MMIO_BASE, MMIO_EN);
    assign cap_kind = decode(cap_addr, RAM_BYTES, MMIO_BASE, MMIO_EN);

    assign load_done = (next_state == ST_RESP) && !eff_we;
    assign ram_re    = load_done && (rd_kind == K_RAM);
    assign ram_we    = (state == ST_RESP) && cap_we && (cap_kind == K_RAM);
    // Reads occur on RESP entry and writes on RESP exit, so one port suffices.
    assign ram_addr  = eff_addr[AW+1:2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        case (state)
            ST_IDLE: if (req) next_state = (WS == '0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (wcnt == WCNT_W'(1)) next_state = ST_RESP;
            ST_RESP: begin
                ready      = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt      <= '0;
            cap_addr  <= '0;
            cap_we    <= 1'b0;
            cap_wdata <= '0;
        end else if (state == ST_IDLE && req) begin
            wcnt      <= WS;
            cap_addr  <= addr;
            cap_we    <= memwrite;
            cap_wdata <= writedata;
        end else if (state == ST_WAIT) begin
            wcnt      <= wcnt - WCNT_W'(1);
        end
    end

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .re   (ram_re),
        .addr (ram_addr),
        .wdata(cap_wdata),
        .rdata(ram_q)
    );

    always_comb begin
        mmio_val = 32'h0;
        case (rd_kind)
            K_LED:    mmio_val = {24'h0, led};
            K_CYCLE:  mmio_val = cycle;
            K_ERRCLR: mmio_val = {31'h0, err};
            default:  mmio_val = 32'h0;
        endcase
    end

    // RAM data stays in the RAM output register; everything else is latched here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_reg     <= '0;
            rd_sel_ram <= 1'b0;
        end else if (load_done) begin
            rd_reg     <= mmio_val;
            rd_sel_ram <= (rd_kind == K_RAM);
        end
    end

    assign readdata = rd_sel_ram ? ram_q : rd_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err <= 1'b0;
        else if (state == ST_RESP) begin
            if (cap_kind == K_BAD)
                err <= 1'b1;
            else if (cap_we && cap_kind == K_ERRCLR)
                err <= 1'b0;
        end
    end

`ifdef DMEM_MMIO_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            led <= '0;
        else if (state == ST_RESP && cap_we && cap_kind == K_LED)
            led <= cap_wdata[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cycle <= '0;
        else
            cycle <= cycle + 32'd1;
    end
`else
    assign led   = 8'h0;
    assign cycle = 32'h0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (WAIT_STATES 1 and 0 instances)
module tb_dmem_responder;

    localparam logic [31:0] MB = 32'hFFFF_0000;
`ifdef DMEM_MMIO_EN
    localparam bit M = 1'b1;
`else
    localparam bit M = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_v   [2];
    logic        we_v    [2];
    logic [31:0] addr_v  [2];
    logic [31:0] wd_v    [2];
    logic [31:0] rdata_v [2];
    logic        rdy_v   [2];
    logic [7:0]  led_v   [2];
    logic        err_v   [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0), .MMIO_BASE(MB)) dut0 (
        .clk(clk), .reset_n(reset_n), .req(req_v[0]), .memwrite(we_v[0]),
        .addr(addr_v[0]), .writedata(wd_v[0]), .readdata(rdata_v[0]),
        .ready(rdy_v[0]), .led(led_v[0]), .err(err_v[0])
    );

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(1), .MMIO_BASE(MB)) dut1 (
        .clk(clk), .reset_n(reset_n), .req(req_v[1]), .memwrite(we_v[1]),
        .addr(addr_v[1]), .writedata(wd_v[1]), .readdata(rdata_v[1]),
        .ready(rdy_v[1]), .led(led_v[1]), .err(err_v[1])
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [7:0]  exp_led;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            req_v[0] = 1'b0;
            req_v[1] = 1'b0;
        end
        @(negedge clk);
    endtask

    // lat counts cycles from the accept cycle to the ready cycle.
    task automatic do_txn(input int u, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd,
                          output int lat, output bit ok);
        @(posedge clk);
        #1;
        req_v[u]  = 1'b1;
        we_v[u]   = w;
        addr_v[u] = a;
        wd_v[u]   = d;
        lat = 0;
        ok  = 1'b0;
        rd  = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (rdy_v[u]) begin
                ok = 1'b1;
                rd = rdata_v[u];
            end else begin
                lat++;
            end
        end
        chk($sformatf("ready_seen_u%0d_%h", u, a), 32'(ok), 32'd1);
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input bit c, input logic [31:0] r, input logic e,
                                input logic [7:0] l);
        vec_t v;
        v.we = w; v.addr = a; v.wd = d; v.chk_rd = c;
        v.exp_rd = r; v.exp_err = e; v.exp_led = l;
        return v;
    endfunction

    initial begin
        logic [31:0] rd, c1, c2;
        int          lat;
        bit          ok;
        int          rdy_cnt;
        logic [7:0]  la5;

        la5 = M ? 8'hA5 : 8'h00;
        vecs[0]  = mk(1, 32'h10,  32'hCAFE_F00D, 0, 32'h0,          0,      8'h00);
        vecs[1]  = mk(0, 32'h10,  32'h0,         1, 32'hCAFE_F00D,  0,      8'h00);
        vecs[2]  = mk(1, 32'h00,  32'h1122_3344, 0, 32'h0,          0,      8'h00);
        vecs[3]  = mk(1, 32'hFC,  32'hA5A5_5A5A, 0, 32'h0,          0,      8'h00);
        vecs[4]  = mk(0, 32'h00,  32'h0,         1, 32'h1122_3344,  0,      8'h00);
        vecs[5]  = mk(0, 32'hFC,  32'h0,         1, 32'hA5A5_5A5A,  0,      8'h00);
        vecs[6]  = mk(1, MB,      32'h0000_01A5, 0, 32'h0,          !M,     la5);
        vecs[7]  = mk(0, MB,      32'h0,         1, {24'h0, la5},   !M,     la5);
        vecs[8]  = mk(0, 32'h13,  32'h0,         1, 32'h0,          1,      la5);
        vecs[9]  = mk(1, 32'h11,  32'hDEAD_BEEF, 0, 32'h0,          1,      la5);
        vecs[10] = mk(0, 32'h10,  32'h0,         1, 32'hCAFE_F00D,  1,      la5);
        vecs[11] = mk(0, MB + 8,  32'h0,         1, {31'h0, M},     1,      la5);
        vecs[12] = mk(1, MB + 8,  32'h0,         0, 32'h0,          !M,     la5);
        vecs[13] = mk(0, 32'h100, 32'h0,         1, 32'h0,          1,      la5);
        vecs[14] = mk(1, MB + 8,  32'h0,         0, 32'h0,          !M,     la5);
        vecs[15] = mk(1, MB + 4,  32'h1234_5678, 0, 32'h0,          !M,     la5);
        vecs[16] = mk(0, MB + 12, 32'h0,         1, 32'h0,          1,      la5);
        vecs[17] = mk(0, MB + 8,  32'h0,         1, {31'h0, M},     1,      la5);

        reset_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req_v[u] = 1'b0; we_v[u] = 1'b0; addr_v[u] = '0; wd_v[u] = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        idle(10);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("rst_ready_u%0d", u), 32'(rdy_v[u]), 32'd0);
            chk($sformatf("rst_readdata_u%0d", u), rdata_v[u], 32'd0);
            chk($sformatf("rst_led_u%0d", u), 32'(led_v[u]), 32'd0);
            chk($sformatf("rst_err_u%0d", u), 32'(err_v[u]), 32'd0);
        end

        for (int i = 0; i < 18; i++) begin
            do_txn(1, vecs[i].we, vecs[i].addr, vecs[i].wd, rd, lat, ok);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            if (vecs[i].chk_rd)
                chk($sformatf("vec%0d_readdata", i), rd, vecs[i].exp_rd);
            idle(1);
            chk($sformatf("vec%0d_err", i), 32'(err_v[1]), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_led", i), 32'(led_v[1]), 32'(vecs[i].exp_led));
        end

        do_txn(0, 1'b1, 32'h40, 32'h0BAD_F00D, rd, lat, ok);
        chk("ws0_store_latency", 32'(lat), 32'd1);
        idle(1);
        do_txn(0, 1'b0, 32'h40, 32'h0, rd, lat, ok);
        chk("ws0_load_latency", 32'(lat), 32'd1);
        chk("ws0_load_data", rd, 32'h0BAD_F00D);
        do_txn(0, 1'b0, MB + 4, 32'h0, c1, lat, ok);
        do_txn(0, 1'b0, MB + 4, 32'h0, c2, lat, ok);
        chk("ws0_b2b_latency", 32'(lat), 32'd1);
        chk("cycle_delta", c2 - c1, M ? 32'd2 : 32'd0);
        idle(1);
        chk("ws0_cycle_err", 32'(err_v[0]), 32'(!M));

        do_txn(1, 1'b1, 32'h20, 32'h1111_1111, rd, lat, ok);
        idle(1);
        @(posedge clk);
        #1;
        req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 32'h20; wd_v[1] = 32'h2222_2222;
        @(negedge clk);
        chk("abort_accept_ready", 32'(rdy_v[1]), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b0;
        rdy_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rdy_v[1]) rdy_cnt++;
        end
        @(posedge clk);
        #1;
        req_v[1] = 1'b0;
        reset_n  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rdy_v[1]) rdy_cnt++;
        end
        chk("abort_no_ready", 32'(rdy_cnt), 32'd0);
        chk("abort_led", 32'(led_v[1]), 32'd0);
        chk("abort_err", 32'(err_v[1]), 32'd0);
        chk("abort_readdata", rdata_v[1], 32'd0);
        do_txn(1, 1'b0, 32'h20, 32'h0, rd, lat, ok);
        chk("abort_prior_contents", rd, 32'h1111_1111);
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the processor's load/store port: accepts word requests (address, write strobe, write data), services them from an internal word RAM or a small memory-mapped register bank, and returns read data with a `ready` completion pulse after a fixed, parameterised wait-state count. It sits between the core's data port (`aluout`/`writedata`/`memwrite`/`readdata`) and the system, and is the responder end of that interface. It adds a request/ready handshake so the core can stall on slow memory.

## Interface
- `DEPTH_WORDS`, 64: RAM depth in 32-bit words; power of two, 16..1024.
- `WAIT_STATES`, 1: extra cycles between request accept and completion; 0..15.
- `MMIO_BASE`, 32'hFFFF_0000: base byte address of the register bank.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  request valid; held high with `addr`/`memwrite`/`writedata` stable until `ready`.
- `memwrite`  in  1  1 = store, 0 = load.
- `addr`  in  32  byte address (from `aluout`).
- `writedata`  in  32  store data.
- `readdata`  out  32  load data; valid in the `ready` cycle, held until next completion.
- `ready`  out  1  one-cycle completion pulse.
- `led`  out  8  MMIO output register.
- `err`  out  1  sticky access-error flag.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req`=1 captures `addr`, `memwrite`, `writedata`, loads wait counter with `WAIT_STATES`; next state WAIT if `WAIT_STATES`>0, else RESP.
- WAIT: counter decrements each cycle; at 1 -> RESP.
- RESP: `ready`=1 for exactly this cycle; store commits at this clock edge; load data registered into `readdata` on entry to RESP. Next state IDLE unconditionally.
- `req` seen high in IDLE the cycle after RESP starts a new transaction; initiator must drop `req` then if it has nothing new.
- `req` dropped during WAIT: transaction still completes (captured values used).
- Decode (captured address):
  - `addr[1:0]`≠0: misaligned; no write, `readdata`=32'h0, `err` set.
  - `addr` < `DEPTH_WORDS`*4: RAM word `addr[log2(DEPTH_WORDS)+1:2]`.
  - `MMIO_BASE`+0: LED; write loads `writedata[7:0]`; read returns {24'b0,`led`}.
  - `MMIO_BASE`+4: free-running 32-bit cycle counter, read-only, wraps 32'hFFFF_FFFF -> 0; writes ignored, no error.
  - `MMIO_BASE`+8: read {31'b0,`err`}; any write clears `err` (clear wins over a simultaneous set — impossible, one access per transaction).
  - else unmapped: reads return 0, writes dropped, `err` set.
- `err` set at the RESP edge of the faulting transaction.

## Timing
- Latency: `ready` asserted `WAIT_STATES`+1 cycles after the accept edge; back-to-back throughput one transaction per `WAIT_STATES`+2 cycles.
- Reset values: `ready`=0, `readdata`=0, `led`=0, `err`=0, cycle counter=0, FSM IDLE. RAM contents not reset.
- Reset asserted mid-transaction: transaction aborted, no store commits, no `ready`.
- Cycle counter increments every cycle out of reset, including during transactions; read value is the count at the RESP-entry edge.

## Configuration
- `DMEM_MMIO_EN` defined: register bank at `MMIO_BASE` as above.
- Not defined: no register bank; `led` tied 0, cycle counter absent; all `MMIO_BASE` addresses decode as unmapped (read 0, write dropped, `err` set). `err` then only clears on reset.

## Structure
- Package `dmem_pkg`: FSM state enum, MMIO offsets (LED 0, CYCLE 4, ERRCLR 8), wait-counter width.
- One sub-module `dmem_ram`: single-port word RAM, synchronous write, synchronous read, parameter `DEPTH_WORDS`.

## Test plan
- Reset then idle 10 cycles -> `ready`=0, `readdata`=0, `led`=0, `err`=0.
- `WAIT_STATES`=1: store 32'hCAFE_F00D to 0x10, then load 0x10 -> each `ready` 2 cycles after accept; load returns 32'hCAFE_F00D.
- Store 32'h0000_01A5 to `MMIO_BASE` -> `led`=8'hA5; load `MMIO_BASE` -> 32'h0000_00A5.
- Load address 0x13 -> `readdata`=0, `err`=1; store to `MMIO_BASE`+8 -> `err`=0.
- Two loads of `MMIO_BASE`+4 back-to-back with `WAIT_STATES`=0 -> values differ by exactly 2.
- Assert `reset_n` low during WAIT of a store to 0x20 -> no `ready`; later load of 0x20 returns prior contents.
